// File: rtl/sub16_pipe.sv
// rtl/sub16_pipe.sv - two-stage 16-bit unsigned subtractor with valid/ready handshake and underflow counter
// Optional: define SUB16_SATURATE_EN to clamp diff to zero whenever borrow is set.
module sub16_pipe #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      diff,
  output logic             borrow,
  output logic [CNT_W-1:0] uflow_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic       s1_valid;
  logic [7:0] s1_lo;
  logic       s1_lo_borrow;
  logic [7:0] s1_a_hi;
  logic [7:0] s1_b_hi;

  logic        adv2;
  logic        adv1;
  logic [8:0]  lo_sub;
  logic [8:0]  hi_sub;
  logic [15:0] res_diff;

  // Stage 2 frees up when empty or being drained; stage 1 can then refill behind it.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // Bit 8 of each 9-bit difference is the borrow out of that byte.
  assign lo_sub = {1'b0, a[7:0]} - {1'b0, b[7:0]};
  assign hi_sub = {1'b0, s1_a_hi} - {1'b0, s1_b_hi} - {8'd0, s1_lo_borrow};

`ifdef SUB16_SATURATE_EN
  assign res_diff = hi_sub[8] ? 16'h0000 : {hi_sub[7:0], s1_lo};
`else
  assign res_diff = {hi_sub[7:0], s1_lo};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_lo        <= 8'd0;
      s1_lo_borrow <= 1'b0;
      s1_a_hi      <= 8'd0;
      s1_b_hi      <= 8'd0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo        <= lo_sub[7:0];
        s1_lo_borrow <= lo_sub[8];
        s1_a_hi      <= a[15:8];
        s1_b_hi      <= b[15:8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff      <= 16'd0;
      borrow    <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        diff   <= res_diff;
        borrow <= hi_sub[8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uflow_cnt <= '0;
    end else if (out_valid && out_ready && borrow && (uflow_cnt != CNT_MAX)) begin
      uflow_cnt <= uflow_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_sub16_pipe.sv
// tb/tb_sub16_pipe.sv - randomized self-checking bench for sub16_pipe against a queue-based reference model
module tb_sub16_pipe;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      a;
  logic [15:0]      b;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      diff;
  logic             borrow;
  logic [CNT_W-1:0] uflow_cnt;

  sub16_pipe #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .uflow_cnt (uflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        b;
  } res_t;

  res_t q[$];
  int   exp_cnt;
  int   n_checks;
  int   n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t ref_sub(input logic [15:0] x, input logic [15:0] y);
    res_t r;
    int   dv;
    dv  = int'(x) - int'(y);
    r.b = (dv < 0);
    r.d = 16'(dv);
`ifdef SUB16_SATURATE_EN
    if (r.b) r.d = 16'h0000;
`endif
    return r;
  endfunction

  // One clock: drive at negedge, predict handoff/transfer, then check after the rising edge.
  task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ordy, output logic acc);
    logic        hand;
    logic        stall;
    logic [15:0] sd;
    logic        sb;
    res_t        e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    #1;
    acc   = iv && in_ready;
    hand  = out_valid && ordy;
    stall = out_valid && !ordy;
    sd    = diff;
    sb    = borrow;
    if (hand) begin
      if (q.size() == 0) begin
        check("result_expected_at_handoff", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("borrow", 32'(borrow), 32'(e.b));
        if (e.b && exp_cnt < CNT_MAX) exp_cnt++;
      end
    end
    if (acc) q.push_back(ref_sub(ia, ib));
    @(posedge clk);
    #1;
    if (hand) check("uflow_cnt", 32'(uflow_cnt), 32'(exp_cnt));
    if (stall) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_diff", 32'(diff), 32'(sd));
      check("stall_borrow", 32'(borrow), 32'(sb));
    end
  endtask

  task automatic send(input logic [15:0] ia, input logic [15:0] ib, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, ia, ib, ordy, acc);
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'd0, 16'd0, 1'b1, acc);
  endtask

  // Asserts reset immediately (possibly mid-cycle) and checks the asynchronous clear.
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_uflow_cnt", 32'(uflow_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic acc;
    int   seq [5];
    seq = '{1, 2, 3, 3, 3};
    n_checks  = 0;
    n_fail    = 0;
    exp_cnt   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'd0;
    b         = 16'd0;
    #12;
    do_reset();

    // Latency: transfer at edge N, result visible after edge N+1.
    cycle(1'b1, 16'h1234, 16'h0034, 1'b1, acc);
    check("lat_accept", 32'(acc), 32'd1);
    check("lat_valid_n", 32'(out_valid), 32'd0);
    cycle(1'b0, 16'd0, 16'd0, 1'b0, acc);
    check("lat_valid_n1", 32'(out_valid), 32'd1);
    check("lat_diff", 32'(diff), 32'h1200);
    check("lat_borrow", 32'(borrow), 32'd0);
    drain(2);

    send(16'h0100, 16'h0001, 1'b1);
    send(16'h0000, 16'h0001, 1'b1);
    send(16'h5A5A, 16'h5A5A, 1'b1);
    send(16'h0000, 16'hFFFF, 1'b1);
    drain(3);
    check("directed_drained", 32'(q.size()), 32'd0);

    // Backpressure: two results buffered, third must wait.
    send(16'h2000, 16'h0001, 1'b0);
    send(16'h3000, 16'h0002, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'hABCD, 16'h1111, 1'b0, acc);
      check("full_no_accept", 32'(acc), 32'd0);
    end
    send(16'hABCD, 16'h1111, 1'b1);
    drain(4);
    check("bp_drained", 32'(q.size()), 32'd0);

    // Counter saturation with CNT_W=2.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(16'h0000, 16'(5 + i), 1'b1);
      drain(3);
      check("uflow_seq", 32'(uflow_cnt), 32'(seq[i]));
    end

    // Reset with both stages full: nothing stale may emerge.
    send(16'h0001, 16'h0002, 1'b0);
    send(16'h0003, 16'h0004, 1'b0);
    check("pre_rst_full", 32'(out_valid), 32'd1);
    #2;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 16'd0, 16'd0, 1'b1, acc);
      check("no_stale_after_rst", 32'(out_valid), 32'd0);
    end

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      case ($urandom_range(0, 3))
        0: begin ra = 16'($urandom); rb = ra; end
        1: begin ra = 16'($urandom_range(0, 255)); rb = 16'($urandom); end
        2: begin ra = 16'h0000; rb = 16'hFFFF; end
        default: begin ra = 16'($urandom); rb = 16'($urandom); end
      endcase
      cycle($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0, acc);
    end
    drain(4);
    check("random_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
